// File: rtl/lu_serial_arbiter.sv
// lu_serial_arbiter
//   Shares one external 1-bit logic unit (OR/NOR/AND/NAND) between two
//   clients. A transaction is a WIDTH-bit bitwise op, run LSB-first one
//   bit per clock. Clients are arbitrated round-robin.
//
// Ports
//   clk, reset            clock (rising edge), async active-high reset
//   req0/a0/b0/op0        client 0 request level, operands, opcode
//   req1/a1/b1/op1        client 1 request level, operands, opcode
//   gnt0, gnt1            one-cycle grant pulse (first RUN cycle)
//   busy                  high in RUN and DONE
//   done, done_id         one-cycle completion pulse and client served
//   result                last completed result, held until next done
//   lu_a, lu_b            bit operands driven to the external LU
//   lu_sel_op             LU invert select (op[0])
//   lu_sel_group          LU group select, 1 = AND group (op[1])
//   lu_s                  LU output, sampled on the same edge
module lu_serial_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [1:0]       op0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [1:0]       op1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] result,
  output logic             lu_a,
  output logic             lu_b,
  output logic             lu_sel_op,
  output logic             lu_sel_group,
  input  logic             lu_s
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic             prio;     // client that wins a tie (the one not served last)
  logic             id_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  // Bits collected so far; the final bit comes straight from lu_s, so
  // one bit less than WIDTH is enough.
  logic [WIDTH-2:0] res;

  logic             any_req;
  logic             win;
  logic [WIDTH-1:0] win_a;
  logic [WIDTH-1:0] win_b;
  logic [1:0]       win_op;
  logic             last_bit;
  logic [WIDTH-1:0] res_next;

  assign any_req  = req0 | req1;
  assign win      = (req0 & req1) ? prio : req1;
  assign win_a    = win ? a1 : a0;
  assign win_b    = win ? b1 : b0;
  assign win_op   = win ? op1 : op0;
  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign res_next = {lu_s, res};

  // Control and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      prio         <= 1'b0;
      id_q         <= 1'b0;
      cnt          <= '0;
      gnt0         <= 1'b0;
      gnt1         <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      done_id      <= 1'b0;
      result       <= '0;
      lu_a         <= 1'b0;
      lu_b         <= 1'b0;
      lu_sel_op    <= 1'b0;
      lu_sel_group <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state        <= RUN;
            id_q         <= win;
            prio         <= ~win;
            cnt          <= '0;
            gnt0         <= ~win;
            gnt1         <= win;
            busy         <= 1'b1;
            lu_a         <= win_a[0];
            lu_b         <= win_b[0];
            lu_sel_group <= win_op[1];
            lu_sel_op    <= win_op[0];
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (last_bit) begin
            state        <= DONE;
            done         <= 1'b1;
            done_id      <= id_q;
            result       <= res_next;
            lu_a         <= 1'b0;
            lu_b         <= 1'b0;
            lu_sel_group <= 1'b0;
            lu_sel_op    <= 1'b0;
          end else begin
            // Present the next operand bit, which is bit 1 before the shift.
            lu_a <= sa[1];
            lu_b <= sb[1];
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand and result shift registers
  always_ff @(posedge clk) begin
    if (state == IDLE && any_req) begin
      sa <= win_a;
      sb <= win_b;
    end else if (state == RUN) begin
      sa  <= sa >> 1;
      sb  <= sb >> 1;
      res <= res_next[WIDTH-1:1];
    end
  end

endmodule

// File: tb/tb_lu_serial_arbiter.sv
module tb_lu_serial_arbiter;
  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0, req1;
  logic [WIDTH-1:0] a0, b0, a1, b1;
  logic [1:0]       op0, op1;
  logic             gnt0, gnt1, busy, done, done_id;
  logic [WIDTH-1:0] result;
  logic             lu_a, lu_b, lu_sel_op, lu_sel_group;
  logic             lu_s;

  lu_serial_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .a0(a0), .b0(b0), .op0(op0),
    .req1(req1), .a1(a1), .b1(b1), .op1(op1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
    .result(result), .lu_a(lu_a), .lu_b(lu_b),
    .lu_sel_op(lu_sel_op), .lu_sel_group(lu_sel_group), .lu_s(lu_s)
  );

  always #5 clk = ~clk;

  // The external 1-bit logic unit.
  assign lu_s = lu_sel_group ? ((lu_a & lu_b) ^ lu_sel_op) : ((lu_a | lu_b) ^ lu_sel_op);

  typedef struct {
    bit               id;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] res;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   gnt_cyc = 0;
  int   bitidx = 0;
  int   gnt_cnt0 = 0;
  int   gnt_cnt1 = 0;
  int   busy_low = 0;
  int   done_cycs[$];
  int   done_bl[$];
  logic [WIDTH-1:0] hold = '0;
  bit   rr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [WIDTH-1:0] lu_word(input logic [1:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   return a | b;
      2'b01:   return ~(a | b);
      2'b10:   return a & b;
      default: return ~(a & b);
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expectations on done, checks LU drive while running.
  always @(negedge clk) begin : mon
    exp_t e;
    if (reset) begin
      q.delete();
      hold   = '0;
      bitidx = 0;
    end else begin
      if (!busy) busy_low++;
      if (gnt0 || gnt1) begin
        gnt_cyc = cyc;
        bitidx  = 0;
        if (gnt0) gnt_cnt0++;
        if (gnt1) gnt_cnt1++;
        check("gnt_busy", busy, 1);
      end
      if (busy && !done && q.size() > 0 && bitidx < WIDTH) begin
        check("lu_sel", {lu_sel_group, lu_sel_op}, q[0].op);
        check("lu_ab", {lu_a, lu_b}, {q[0].a[bitidx], q[0].b[bitidx]});
        bitidx++;
      end
      if (!busy || done)
        check("lu_idle_zero", {lu_a, lu_b, lu_sel_group, lu_sel_op}, 0);
      if (done) begin
        if (q.size() == 0) begin
          check("spurious_done", 1, 0);
        end else begin
          e = q.pop_front();
          check("done_id", done_id, e.id);
          check("result", result, e.res);
          check("latency", cyc - gnt_cyc, WIDTH);
          hold = e.res;
        end
        done_cycs.push_back(cyc);
        done_bl.push_back(busy_low);
      end else begin
        check("result_hold", result, hold);
      end
    end
  end

  task automatic expect_txn(input bit id);
    exp_t e;
    e.id  = id;
    e.op  = id ? op1 : op0;
    e.a   = id ? a1 : a0;
    e.b   = id ? b1 : b0;
    e.res = lu_word(e.op, e.a, e.b);
    q.push_back(e);
  endtask

  task automatic wait_gnt(output bit id_o);
    int n = 0;
    @(negedge clk);
    while (!(gnt0 || gnt1) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!(gnt0 || gnt1)) check("gnt_timeout", 0, 1);
    id_o = gnt1;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      check("drain_timeout", q.size(), 0);
      q.delete();
    end
    @(negedge clk);
  endtask

  // Raise the given requests and serve them until both are dropped.
  task automatic serve(input bit r0, input bit r1);
    bit w;
    bit g;
    @(negedge clk);
    req0 = r0;
    req1 = r1;
    while (req0 || req1) begin
      w = (req0 && req1) ? rr : req1;
      expect_txn(w);
      wait_gnt(g);
      check("arb_winner", g, w);
      if (g) req1 = 1'b0;
      else   req0 = 1'b0;
      rr = ~w;
    end
    wait_empty();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #2 reset = 1'b0;
    rr = 1'b0;
  endtask

  initial begin : drv
    bit g;
    int g1;
    int bl0;
    int n;
    int gc0;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; op0 = '0;
    a1 = '0; b1 = '0; op1 = '0;
    repeat (3) @(negedge clk);
    check("reset_outs",
          {gnt0, gnt1, busy, done, done_id, result, lu_a, lu_b, lu_sel_op, lu_sel_group}, 0);
    #2 reset = 1'b0;

    // AND, then NAND / OR / NOR on the same operands
    a0 = 8'hF0; b0 = 8'hCC; op0 = 2'b10;
    serve(1, 0);
    check("t1_and", result, 8'hC0);
    op0 = 2'b11; serve(1, 0); check("t2_nand", result, 8'h3F);
    op0 = 2'b00; serve(1, 0); check("t2_or",   result, 8'hFC);
    op0 = 2'b01; serve(1, 0); check("t2_nor",  result, 8'h03);

    // Simultaneous requests after reset, then with client 1 owed priority
    do_reset();
    op0 = 2'b10;
    a1 = 8'h0F; b1 = 8'h30; op1 = 2'b00;
    serve(1, 1);
    check("t3_second_c1", result, 8'h3F);
    serve(1, 0);
    serve(1, 1);
    check("t3_second_c0", result, 8'hC0);

    // Client 1 holds its request over three transactions
    a1 = 8'h55; b1 = 8'h0F; op1 = 2'b01;
    @(negedge clk);
    req1 = 1'b1;
    g1 = gnt_cnt1;
    bl0 = 0;
    for (int i = 0; i < 3; i++) begin
      expect_txn(1);
      wait_gnt(g);
      check("t4_gnt", g, 1);
      if (i == 0) bl0 = busy_low;
    end
    req1 = 1'b0;
    rr = 1'b0;
    wait_empty();
    n = done_cycs.size();
    check("t4_gnt_count", gnt_cnt1 - g1, 3);
    if (n >= 3) begin
      check("t4_period_a", done_cycs[n-2] - done_cycs[n-3], WIDTH + 2);
      check("t4_period_b", done_cycs[n-1] - done_cycs[n-2], WIDTH + 2);
      check("t4_busy_low", done_bl[n-1] - bl0, 2);
    end else begin
      check("t4_done_count", n, 3);
    end

    // Reset in the fourth RUN cycle aborts the transaction
    a0 = 8'hF0; b0 = 8'hCC; op0 = 2'b10;
    @(negedge clk);
    req0 = 1'b1;
    expect_txn(0);
    wait_gnt(g);
    req0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("t5_busy_pre", busy, 1);
    reset = 1'b1;
    #1;
    check("t5_outs_zero",
          {gnt0, gnt1, busy, done, done_id, result, lu_a, lu_b, lu_sel_op, lu_sel_group}, 0);
    rr = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    n = done_cycs.size();
    repeat (15) @(negedge clk);
    check("t5_no_done", done_cycs.size(), n);
    serve(1, 0);
    check("t5_after", result, 8'hC0);

    // Operand changes and a short req1 pulse during RUN
    op0 = 2'b11;
    @(negedge clk);
    req0 = 1'b1;
    expect_txn(0);
    wait_gnt(g);
    req0 = 1'b0;
    @(negedge clk);
    a0 = 8'($urandom); b0 = 8'($urandom); req1 = 1'b1;
    @(negedge clk);
    req1 = 1'b0;
    g1 = gnt_cnt1;
    wait_empty();
    check("t6_result", result, 8'h3F);
    repeat (2 * WIDTH) @(negedge clk);
    check("t6_no_gnt1", gnt_cnt1, g1);
    rr = 1'b1;

    // req1 raised during RUN and held is served on return to IDLE
    a0 = 8'hAA; b0 = 8'h0F; op0 = 2'b00;
    a1 = 8'h3C; b1 = 8'hF0; op1 = 2'b10;
    @(negedge clk);
    req0 = 1'b1;
    expect_txn(0);
    wait_gnt(g);
    check("t6_first", g, 0);
    gc0 = cyc;
    req0 = 1'b0;
    req1 = 1'b1;
    expect_txn(1);
    wait_gnt(g);
    check("t6_second", g, 1);
    check("t6_gnt_gap", cyc - gc0, WIDTH + 2);
    req1 = 1'b0;
    rr = 1'b0;
    wait_empty();
    check("t6_final", result, 8'h30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
